// File: rtl/bb_bus_arbiter.sv
// Round-robin arbiter for the bit-serial system bus, with one outstanding split transaction.
// Optional grant hold limit: define ARB_HOLD_LIMIT_EN.
module bb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int HOLD_LIMIT  = 256
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         breq,
    output logic [NUM_MASTERS-1:0]         bgrant,
    output logic [$clog2(NUM_MASTERS)-1:0] msel,
    output logic [NUM_MASTERS-1:0]         split,
    input  logic                           slave_split,
    input  logic                           slave_split_release,
    output logic                           bus_busy,
    output logic                           split_err
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || HOLD_LIMIT < 2) begin : g_param_check
        $error("bb_bus_arbiter: unsupported NUM_MASTERS/HOLD_LIMIT");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                 state_r, state_nxt;
    logic [NUM_MASTERS-1:0] bgrant_nxt, split_nxt, parked;
    logic [IDX_W-1:0]       msel_nxt, split_owner_r, split_owner_nxt, rr_ptr_r, rr_ptr_nxt;
    logic                   split_valid_r, split_valid_nxt, resume_r, resume_nxt;
    logic                   split_err_nxt, bus_busy_nxt;
    logic [IDX_W:0]         pick;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = ($clog2(HOLD_LIMIT) > 8) ? $clog2(HOLD_LIMIT) : 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt;
`endif

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MASTERS-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Returns {found, index} of the first requester at or after ptr, with wrap.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] sel;
        logic             found;
        idx   = ptr;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = next_idx(idx);
        end
        return {found, sel};
    endfunction

    always_comb begin
        state_nxt       = state_r;
        bgrant_nxt      = bgrant;
        msel_nxt        = msel;
        split_nxt       = split;
        split_valid_nxt = split_valid_r;
        split_owner_nxt = split_owner_r;
        resume_nxt      = resume_r;
        rr_ptr_nxt      = rr_ptr_r;
        split_err_nxt   = split_err;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_nxt    = hold_cnt_r;
`endif
        parked = (split_valid_r && !resume_r) ? onehot(split_owner_r) : '0;
        pick   = rr_pick(breq & ~parked, rr_ptr_r);

        // A parked master that gives up its request cancels the split entirely.
        if (split_valid_r && !breq[split_owner_r]) begin
            split_valid_nxt = 1'b0;
            resume_nxt      = 1'b0;
            split_nxt       = '0;
        end else if (split_valid_r && slave_split_release) begin
            split_nxt  = '0;
            resume_nxt = 1'b1;
        end

        case (state_r)
            IDLE: begin
                if (resume_r && split_valid_r && breq[split_owner_r]) begin
                    bgrant_nxt      = onehot(split_owner_r);
                    msel_nxt        = split_owner_r;
                    resume_nxt      = 1'b0;
                    split_valid_nxt = 1'b0;
                    state_nxt       = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_nxt    = '0;
`endif
                end else if (pick[IDX_W]) begin
                    bgrant_nxt   = onehot(pick[IDX_W-1:0]);
                    msel_nxt     = pick[IDX_W-1:0];
                    state_nxt    = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
                if (!breq[msel]) begin
                    bgrant_nxt = '0;
                    rr_ptr_nxt = next_idx(msel);
                    state_nxt  = IDLE;
                end else if (slave_split && !split_valid_r) begin
                    split_owner_nxt = msel;
                    split_valid_nxt = 1'b1;
                    resume_nxt      = 1'b0;
                    split_nxt       = onehot(msel);
                    bgrant_nxt      = '0;
                    rr_ptr_nxt      = next_idx(msel);
                    state_nxt       = IDLE;
                end else begin
                    if (slave_split) begin
                        split_err_nxt = 1'b1;
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_cnt_r == HOLD_LAST) begin
                        bgrant_nxt = '0;
                        rr_ptr_nxt = next_idx(msel);
                        state_nxt  = IDLE;
                    end else begin
                        hold_cnt_nxt = hold_cnt_r + 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase

        bus_busy_nxt = |bgrant_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            bgrant        <= '0;
            msel          <= '0;
            split         <= '0;
            split_valid_r <= 1'b0;
            split_owner_r <= '0;
            resume_r      <= 1'b0;
            rr_ptr_r      <= '0;
            split_err     <= 1'b0;
            bus_busy      <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_r    <= '0;
`endif
        end else begin
            state_r       <= state_nxt;
            bgrant        <= bgrant_nxt;
            msel          <= msel_nxt;
            split         <= split_nxt;
            split_valid_r <= split_valid_nxt;
            split_owner_r <= split_owner_nxt;
            resume_r      <= resume_nxt;
            rr_ptr_r      <= rr_ptr_nxt;
            split_err     <= split_err_nxt;
            bus_busy      <= bus_busy_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_r    <= hold_cnt_nxt;
`endif
        end
    end

endmodule
